// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light encodings, phase codes and default timing for the intersection controller
package traffic_pkg;

  localparam logic [2:0] CAR_RED    = 3'b100;
  localparam logic [2:0] CAR_YELLOW = 3'b010;
  localparam logic [2:0] CAR_GREEN  = 3'b001;

  localparam logic [2:0] WALK_STOP  = 3'b100;
  localparam logic [2:0] WALK_CLEAR = 3'b010;
  localparam logic [2:0] WALK_GO    = 3'b001;

  localparam int DEF_T_GREEN_MIN = 8;
  localparam int DEF_T_GREEN_MAX = 20;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALL_RED   = 2;
  localparam int DEF_T_WALK      = 5;

  typedef enum logic [2:0] {
    AR_H2V   = 3'd0,
    H_GREEN  = 3'd1,
    H_YELLOW = 3'd2,
    AR_V2H   = 3'd3,
    V_GREEN  = 3'd4,
    V_YELLOW = 3'd5
  } phase_t;

  function automatic logic [2:0] car_light(input phase_t p, input logic vert);
    phase_t g;
    phase_t y;
    g = vert ? V_GREEN : H_GREEN;
    y = vert ? V_YELLOW : H_YELLOW;
    if (p == g) return CAR_GREEN;
    if (p == y) return CAR_YELLOW;
    return CAR_RED;
  endfunction

  function automatic logic [2:0] walker_light(input logic green, input logic show,
                                              input logic [7:0] t, input logic [7:0] walk_len);
    if (!(green && show)) return WALK_STOP;
    if (t < walk_len) return WALK_GO;
    return WALK_CLEAR;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - 8-bit saturating phase timer with synchronous clear
module traffic_phase_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// rtl/traffic_phase_arbiter.sv - two-way intersection phase controller with walk latches and preemption
// Light registers load the decode of the next phase and timer, so they always match the state register.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_GREEN_MAX = DEF_T_GREEN_MAX,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALL_RED   = DEF_T_ALL_RED,
  parameter int T_WALK      = DEF_T_WALK
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_h_car_det,
  input  logic       i_v_car_det,
  input  logic       i_h_walk_req,
  input  logic       i_v_walk_req,
  input  logic       i_emg,
  input  logic       i_emg_dir,
  output logic [2:0] o_h_car_traffic,
  output logic [2:0] o_v_car_traffic,
  output logic [2:0] o_h_walker_traffic,
  output logic [2:0] o_v_walker_traffic,
  output logic [2:0] o_state
);

  localparam logic [7:0] AR_LAST   = 8'(T_ALL_RED - 1);
  localparam logic [7:0] YEL_LAST  = 8'(T_YELLOW - 1);
  localparam logic [7:0] GMIN_LAST = 8'(T_GREEN_MIN - 1);
  localparam logic [7:0] GMAX_LAST = 8'(T_GREEN_MAX - 1);
  localparam logic [7:0] WALK_LEN  = 8'(T_WALK);

  phase_t     state, state_next;
  logic [7:0] timer, timer_next;
  logic       timer_clr, green_restart;
  logic       h_pend, v_pend, h_pend_next, v_pend_next;
  logic       h_show, v_show, h_show_next, v_show_next;
  logic       hold, hold_next;
  logic       emg_h, emg_v;

  traffic_phase_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clr),
    .count   (timer)
  );

  assign emg_h = i_emg & ~i_emg_dir;
  assign emg_v = i_emg & i_emg_dir;

  always_comb begin
    state_next    = state;
    green_restart = 1'b0;
    case (state)
      AR_V2H, AR_H2V: begin
        if (timer == AR_LAST) begin
          if (i_emg)                state_next = i_emg_dir ? V_GREEN : H_GREEN;
          else if (state == AR_V2H) state_next = H_GREEN;
          else                      state_next = V_GREEN;
        end
      end
      H_GREEN: begin
        if (emg_v) begin
          state_next = H_YELLOW;
        end else if (!emg_h) begin
          if (hold) green_restart = 1'b1;
          else if ((i_v_car_det | v_pend) && (timer >= GMIN_LAST || timer == GMAX_LAST))
            state_next = H_YELLOW;
        end
      end
      H_YELLOW: if (timer == YEL_LAST) state_next = AR_H2V;
      V_GREEN: begin
        if (emg_h) begin
          state_next = V_YELLOW;
        end else if (!emg_v) begin
          if (hold) green_restart = 1'b1;
          else if ((i_h_car_det | h_pend) && (timer >= GMIN_LAST || timer == GMAX_LAST))
            state_next = V_YELLOW;
        end
      end
      V_YELLOW: if (timer == YEL_LAST) state_next = AR_V2H;
      default:  state_next = AR_V2H;
    endcase

    // Mirrors the timer sub-module so the output decode sees the value the timer is about to hold.
    timer_clr  = (state_next != state) || green_restart;
    timer_next = timer_clr ? 8'd0 : ((timer == 8'hFF) ? timer : timer + 8'd1);

    hold_next   = (state_next == H_GREEN && emg_h) || (state_next == V_GREEN && emg_v);
    h_pend_next = h_pend | i_h_walk_req;
    v_pend_next = v_pend | i_v_walk_req;
    h_show_next = h_show;
    v_show_next = v_show;

    // A request arriving on the entry edge stays latched for the following green.
    if (state_next == H_GREEN && state != H_GREEN) begin
      h_show_next = h_pend & ~hold_next;
      if (!hold_next) h_pend_next = i_h_walk_req;
    end
    if (state_next == V_GREEN && state != V_GREEN) begin
      v_show_next = v_pend & ~hold_next;
      if (!hold_next) v_pend_next = i_v_walk_req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= AR_V2H;
      h_pend             <= 1'b0;
      v_pend             <= 1'b0;
      h_show             <= 1'b0;
      v_show             <= 1'b0;
      hold               <= 1'b0;
      o_h_car_traffic    <= CAR_RED;
      o_v_car_traffic    <= CAR_RED;
      o_h_walker_traffic <= WALK_STOP;
      o_v_walker_traffic <= WALK_STOP;
      o_state            <= AR_V2H;
    end else begin
      state              <= state_next;
      h_pend             <= h_pend_next;
      v_pend             <= v_pend_next;
      h_show             <= h_show_next;
      v_show             <= v_show_next;
      hold               <= hold_next;
      o_h_car_traffic    <= car_light(state_next, 1'b0);
      o_v_car_traffic    <= car_light(state_next, 1'b1);
      o_h_walker_traffic <= walker_light(state_next == H_GREEN, h_show_next & ~hold_next,
                                         timer_next, WALK_LEN);
      o_v_walker_traffic <= walker_light(state_next == V_GREEN, v_show_next & ~hold_next,
                                         timer_next, WALK_LEN);
      o_state            <= state_next;
    end
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// tb/tb_traffic_phase_arbiter.sv - scoreboard bench for traffic_phase_arbiter
module tb_traffic_phase_arbiter;

  localparam int GMIN = 8, GMAX = 20, TY = 3, TAR = 2, TW = 5;
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  localparam int K_AR = 0, K_GREEN = 1, K_YEL = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic h_car = 0, v_car = 0, h_req = 0, v_req = 0, emg = 0, emg_dir = 0;
  logic [2:0] h_light, v_light, h_walker, v_walker, st;

  traffic_phase_arbiter #(
    .T_GREEN_MIN(GMIN), .T_GREEN_MAX(GMAX), .T_YELLOW(TY), .T_ALL_RED(TAR), .T_WALK(TW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_h_car_det(h_car), .i_v_car_det(v_car),
    .i_h_walk_req(h_req), .i_v_walk_req(v_req),
    .i_emg(emg), .i_emg_dir(emg_dir),
    .o_h_car_traffic(h_light), .o_v_car_traffic(v_light),
    .o_h_walker_traffic(h_walker), .o_v_walker_traffic(v_walker),
    .o_state(st)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic [14:0] exp_q[$];
  logic [14:0] mon_exp, mon_act;

  // Reference model: phase kind (all-red/green/yellow) plus the direction it serves.
  int m_kind, m_dir, m_t;
  bit m_pend[2];
  bit m_show, m_hold;

  function automatic void model_reset();
    m_kind = K_AR; m_dir = 0; m_t = 0;
    m_pend[0] = 0; m_pend[1] = 0; m_show = 0; m_hold = 0;
  endfunction

  function automatic void model_step(input bit hc, input bit vc, input bit hr, input bit vr,
                                     input bit e, input bit ed);
    bit car[2], req[2], old_pend[2];
    int nk, nd;
    bit restart, changed;
    car[0] = hc; car[1] = vc; req[0] = hr; req[1] = vr;
    nk = m_kind; nd = m_dir; restart = 0;
    if (m_kind == K_AR) begin
      if (m_t == TAR - 1) begin nk = K_GREEN; if (e) nd = int'(ed); end
    end else if (m_kind == K_YEL) begin
      if (m_t == TY - 1) begin nk = K_AR; nd = 1 - m_dir; end
    end else begin
      if (e && int'(ed) != m_dir) nk = K_YEL;
      else if (!e) begin
        if (m_hold) restart = 1;
        else if ((car[1 - m_dir] || m_pend[1 - m_dir]) && (m_t >= GMIN - 1 || m_t == GMAX - 1))
          nk = K_YEL;
      end
    end
    changed = (nk != m_kind) || (nd != m_dir);
    old_pend = m_pend;
    for (int d = 0; d < 2; d++) m_pend[d] = m_pend[d] | req[d];
    m_hold = e && nk == K_GREEN && int'(ed) == nd;
    if (changed && nk == K_GREEN) begin
      if (m_hold) m_show = 0;
      else begin m_show = old_pend[nd]; m_pend[nd] = req[nd]; end
    end
    m_t = (changed || restart) ? 0 : ((m_t < 255) ? m_t + 1 : 255);
    m_kind = nk; m_dir = nd;
  endfunction

  function automatic logic [14:0] model_out();
    logic [2:0] c[2], w[2];
    int code;
    for (int d = 0; d < 2; d++) begin
      c[d] = (m_dir == d && m_kind == K_GREEN) ? GRN : (m_dir == d && m_kind == K_YEL) ? YEL : RED;
      w[d] = (m_dir == d && m_kind == K_GREEN && m_show && !m_hold) ? ((m_t < TW) ? GRN : YEL) : RED;
    end
    code = (m_kind == K_AR) ? (m_dir ? 0 : 3) : ((m_dir ? 3 : 0) + m_kind);
    return {c[0], c[1], w[0], w[1], 3'(code)};
  endfunction

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %b want %b", name, act, exp); end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin bad++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
  endtask

  task automatic step(input bit hc, input bit vc, input bit hr, input bit vr, input bit e, input bit ed);
    @(negedge clk);
    h_car = hc; v_car = vc; h_req = hr; v_req = vr; emg = e; emg_dir = ed;
    @(posedge clk);
    model_step(hc, vc, hr, vr, e, ed);
    exp_q.push_back(model_out());
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    h_car = 0; v_car = 0; h_req = 0; v_req = 0; emg = 0; emg_dir = 0;
    model_reset();
    #1;
    check3("rst_h_car", h_light, RED);
    check3("rst_v_car", v_light, RED);
    check3("rst_h_walker", h_walker, RED);
    check3("rst_v_walker", v_walker, RED);
    check3("rst_state", st, 3'd3);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {h_light, v_light, h_walker, v_walker, st};
        total++;
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL scoreboard cycle %0d: got %h want %h", cyc, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    int n, wc, cc, held, wb;
    bit found, hc, vc, hr, vr, ed;
    int ecnt;

    #1;
    // Idle after reset: two all-red cycles, then rest in H green.
    do_reset();
    idle(); check3("ar_cycle1", h_light, RED);
    idle(); check3("h_green_cycle2", h_light, GRN);
    n = 0;
    for (int i = 0; i < 100; i++) begin idle(); if (h_light == GRN) n++; end
    checki("h_rest_cycles", n, 100);

    // Vertical car demand from H green entry.
    do_reset(); idle(); idle();
    n = -1; cc = -1;
    for (int i = 1; i <= 30 && cc < 0; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (h_light == YEL && n < 0) n = i;
      if (v_light == GRN) cc = i;
    end
    checki("h_yellow_at", n, 8);
    checki("v_green_at", cc, 13);

    // Vertical walk pulse during H green.
    do_reset(); idle(); idle();
    step(0, 0, 0, 1, 0, 0);
    wc = 0; cc = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (v_walker == GRN) wc++;
      if (v_walker == YEL) cc++;
    end
    checki("v_walk_cycles", wc, 5);
    checki("v_clear_cycles", cc, 24);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin step(1, 0, 0, 0, 0, 0); found = (v_light == YEL); end
    checki("v_yellow_reached", int'(found), 1);
    check3("v_walker_in_yellow", v_walker, RED);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin step(0, 1, 0, 0, 0, 0); found = (v_light == GRN); end
    checki("v_green_again", int'(found), 1);
    wc = (v_walker == GRN) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin step(0, 1, 0, 0, 0, 0); if (v_walker == GRN) wc++; end
    checki("v_latch_cleared", wc, 0);

    // Both directions demanding: every green lasts exactly the minimum.
    do_reset(); n = 0;
    for (int i = 0; i < 80; i++) begin
      step(1, 1, 0, 0, 0, 0);
      if (h_light == GRN || v_light == GRN) n++;
      else if (n > 0) begin checki("alt_green_len", n, 8); n = 0; end
    end

    // Emergency toward V arriving at H green timer 2.
    do_reset(); idle(); idle(); idle(); idle();
    step(0, 0, 0, 0, 1, 1); check3("emg_h_yellow", h_light, YEL);
    wb = (h_walker != RED || v_walker != RED) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1);
      if (h_walker != RED || v_walker != RED) wb++;
    end
    check3("emg_v_not_yet", v_light, RED);
    step(0, 0, 0, 0, 1, 1); check3("emg_v_green", v_light, GRN);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, (i % 5) == 0, 0, 1, 1);
      if (v_light == GRN) held++;
      if (h_walker != RED || v_walker != RED) wb++;
    end
    checki("emg_v_held", held, 20);
    checki("emg_walkers_stop", wb, 0);
    n = 0; found = 1;
    for (int i = 0; i < 30 && found; i++) begin
      step(1, 0, 0, 0, 0, 0);
      found = (v_light == GRN);
      if (found) n++;
    end
    checki("post_emg_green_len", n, 8);

    // Walk request on the H green entry edge is served by the next H green.
    do_reset(); idle();
    step(0, 0, 1, 0, 0, 0);
    check3("h_green_entry", h_light, GRN);
    wc = (h_walker == GRN) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin idle(); if (h_walker == GRN) wc++; end
    checki("h_walk_first_green", wc, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin step(0, 1, 0, 0, 0, 0); found = (v_light == GRN); end
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin step(1, 0, 0, 0, 0, 0); found = (h_light == GRN); end
    checki("h_green_second", int'(found), 1);
    check3("h_walk_second_green", h_walker, GRN);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin step(1, 1, 0, 0, 0, 0); found = (v_light == YEL); end
    check3("pre_reset_v_yellow", v_light, YEL);
    do_reset();

    // Randomized traffic with occasional preemption episodes and resets.
    hc = 0; vc = 0; ed = 0; ecnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) hc = !hc;
      if ($urandom_range(0, 15) == 0) vc = !vc;
      hr = ($urandom_range(0, 19) == 0);
      vr = ($urandom_range(0, 19) == 0);
      if (ecnt > 0) ecnt--;
      else if ($urandom_range(0, 149) == 0) begin
        ecnt = int'($urandom_range(5, 40));
        ed = ($urandom_range(0, 1) == 1);
      end
      step(hc, vc, hr, vr, ecnt > 0, ed);
      if ($urandom_range(0, 799) == 0) do_reset();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_arbiter.md
TRAFFIC_PHASE_ARBITER -- requirements
Module: traffic_phase_arbiter

Interface
REQ-001 Parameters: T_GREEN_MIN 8, min green cycles; T_GREEN_MAX 20, max green cycles; T_YELLOW 3, yellow cycles; T_ALL_RED 2, all-red cycles; T_WALK 5, steady walk cycles.
REQ-002 Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_h_car_det  in  1  horizontal vehicle demand, level.
- i_v_car_det  in  1  vertical vehicle demand, level.
- i_h_walk_req  in  1  horizontal pedestrian button, 1-cycle pulse or level.
- i_v_walk_req  in  1  vertical pedestrian button, 1-cycle pulse or level.
- i_emg  in  1  emergency preemption active, level.
- i_emg_dir  in  1  preemption direction: 0 = H, 1 = V; sampled only while i_emg = 1.
- o_h_car_traffic  out  3  H car light.
- o_v_car_traffic  out  3  V car light.
- o_h_walker_traffic  out  3  H walker light.
- o_v_walker_traffic  out  3  V walker light.
- o_state  out  3  current phase code, for debug.
REQ-003 Car light encoding: 3'b100 red, 3'b010 yellow, 3'b001 green. Walker encoding: 3'b100 don't-walk, 3'b010 flashing/clearing, 3'b001 walk.

Function
REQ-004 Phases: AR_H2V (0), H_GREEN (1), H_YELLOW (2), AR_V2H (3), V_GREEN (4), V_YELLOW (5).
REQ-005 Phase timer: 0 on phase entry; +1 per cycle; saturates at 255. "Expires N" means the phase exits on the cycle where timer == N-1.
REQ-006 Normal sequence: AR_V2H -> H_GREEN -> H_YELLOW -> AR_H2V -> V_GREEN -> V_YELLOW -> AR_V2H.
- AR phases last T_ALL_RED.
- YELLOW phases last T_YELLOW.
REQ-007 X_GREEN ends at the first cycle where timer >= T_GREEN_MIN-1 and opposing demand is set, or where timer == T_GREEN_MAX-1.
- Opposing demand = opposing car_det OR opposing walk latch.
- Without opposing demand, X_GREEN is held indefinitely (rest in green); T_GREEN_MAX applies only once opposing demand exists. The timer keeps counting during rest.
REQ-008 Walk latches h_walk_pend and v_walk_pend:
- Set on the corresponding request.
- Cleared on the entry cycle of the matching GREEN.
- If set and clear occur in the same cycle, set wins; the request is served in the next matching green.
REQ-009 Walker light for direction X during X_GREEN, only if the latch was set at entry:
- walk for timer 0..T_WALK-1;
- clearing from T_WALK until green exit;
- otherwise don't-walk.
REQ-010 Walker light is don't-walk in every non-green phase. If X_GREEN lasts fewer than T_WALK cycles, walk truncates directly to don't-walk.
REQ-011 Exactly one car light is non-red at any time. Both car lights are red in AR phases.
REQ-012 Preemption when i_emg = 1 and i_emg_dir is not the current green direction:
- the current green goes immediately to its YELLOW, ignoring T_GREEN_MIN;
- a YELLOW in progress completes without restart;
- then AR, then green in i_emg_dir.
REQ-013 While i_emg = 1 and the green matches i_emg_dir:
- green is held;
- both walkers are forced to don't-walk;
- walk latches are held, not cleared.
REQ-014 On i_emg deassertion the timer restarts at 0 and REQ-007 applies.
REQ-015 Outputs are registered, decoded from the state register and timer. No combinational input-to-output path.

Reset
REQ-016 Asynchronous assertion of reset_n = 0 forces:
- state AR_V2H, timer 0, both walk latches 0;
- all car lights 3'b100, all walker lights 3'b100, o_state 3.
REQ-017 Reset mid-phase discards all pending requests and any preemption progress.
REQ-018 After deassertion, the first transition is to H_GREEN after T_ALL_RED cycles.

Structure
REQ-019 Package traffic_pkg holds:
- light encodings;
- phase code localparams;
- default timing constants.
REQ-020 One sub-module, traffic_phase_timer: 8-bit saturating up-counter with synchronous clear and async active-low reset.

Verification
REQ-021 Reset release, no demand:
- cycles 0-1: all red;
- cycle 2: H green;
- H green held for 100 cycles.
REQ-022 i_v_car_det = 1 from H_GREEN timer 0:
- yellow at timer 8;
- 3 yellow cycles;
- 2 all-red cycles;
- V green on cycle 13 after H green entry.
REQ-023 i_v_walk_req pulse during H_GREEN:
- V walker shows 001 for 5 cycles, then 010 until V yellow, then 100;
- v_walk_pend clears at V green entry.
REQ-024 i_v_car_det held together with i_h_car_det: greens alternate, each exactly 8 cycles.
REQ-025 i_emg = 1, i_emg_dir = 1 at H_GREEN timer 2:
- H yellow the next cycle;
- V green after 3 + 2 cycles, held while i_emg = 1;
- walkers 100 throughout.
REQ-026 Simultaneous h_walk request and H_GREEN entry: this green shows no walk; the next H green shows walk. Reset asserted mid-V_YELLOW returns all outputs to red immediately.
